axi4_frame_reader_mc: RTL

- Parametrised AXI4 read master that fetches a complete frame from DDR as INCR bursts and streams the beats into an external async pixel FIFO on the write side.
- Supersedes the fixed 64-bit/64-beat frame reader with configurable data width, burst length, frame size and buffer count (N-way frame buffering).
- Adds end-of-frame stop, mid-frame restart handling and a frame-done flag.
- Sits between the PS DDR HP port and the pixel FIFO that feeds the VTG/HDMI path.

---
 rtl/axi4_frame_reader_mc.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_frame_reader_mc.sv
// axi4_frame_reader_mc
// Purpose: AXI4 read master that fetches one frame from DDR as fixed-length
//   INCR bursts and streams the returned beats into the write side of an
//   external pixel FIFO. Supports N-way frame buffering, end-of-frame stop,
//   mid-frame restart (the in-flight burst is drained, never abandoned) and
//   a frame-done flag.
// Ports:
//   clk_100Mhz, rst         clock, synchronous active-high reset
//   frame_start             pulse from the pixel domain (>= 2 clk wide)
//   buf_sel                 buffer index, captured on each frame start
//   fifo_prog_full          FIFO headroom flag, sampled only between bursts
//   fifo_wr_en, fifo_din    FIFO write strobe/data (combinational from R)
//   AR*/R*                  AXI4 read address and read data channels
//   state, addr_offset      debug: FSM state, byte offset of next burst
//   frame_done              set once the last burst of the frame completes
// Optional (macro RD_RESP_CHECK_EN): rd_err (sticky) and rd_err_cnt
//   (saturating) count accepted R beats whose RRESP is not OKAY.
module axi4_frame_reader_mc #(
  parameter int unsigned               AXI_ADDR_WIDTH = 32,
  parameter int unsigned               AXI_DATA_WIDTH = 64,
  parameter int unsigned               BURST_LEN      = 64,
  parameter int unsigned               FRAME_BYTES    = 153600,
  parameter int unsigned               NUM_BUFS       = 2,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0100_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] BUF_STRIDE     = 32'h0010_0000,
  localparam int unsigned              SEL_W          = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [SEL_W-1:0]          buf_sel,
  input  logic                      fifo_prog_full,
  output logic                      fifo_wr_en,
  output logic [AXI_DATA_WIDTH-1:0] fifo_din,
  output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic [3:0]                ARCACHE,
  input  logic [AXI_DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  input  logic                      RLAST,
  output logic                      RREADY,
  output logic [2:0]                state,
  output logic [AXI_ADDR_WIDTH-1:0] addr_offset,
`ifdef RD_RESP_CHECK_EN
  output logic                      rd_err,
  output logic [15:0]               rd_err_cnt,
`endif
  output logic                      frame_done
);

  localparam int unsigned AW = AXI_ADDR_WIDTH;
  localparam int unsigned BB = BURST_LEN * AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_araddr, w_araddr_nxt;
  logic             r_arvalid, w_arvalid_nxt;
  logic             r_rready, w_rready_nxt;
  logic [AW-1:0]    r_offset, w_offset_nxt;
  logic             r_frame_done, w_frame_done_nxt;
  logic             r_restart_pend, w_restart_pend_nxt;
  logic             w_wr_en_c;

  logic [1:0]       r_fs_sync;
  logic             r_fs_d;
  logic             w_fs_rise;
  logic [SEL_W-1:0] r_cur_buf, w_cur_buf_nxt;
  logic [AW-1:0]    r_frame_base;
  logic             w_rbeat, w_rlast;

  // frame_start crosses from the pixel domain: 2-FF sync then rising edge
  assign w_fs_rise     = r_fs_sync[1] & ~r_fs_d;
  assign w_cur_buf_nxt = w_fs_rise ? buf_sel : r_cur_buf;
  assign w_rbeat       = RVALID & r_rready;
  assign w_rlast       = w_rbeat & RLAST;

  // Sync chain and buffer capture; frame base follows the newly captured index
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      r_fs_sync    <= 2'b00;
      r_fs_d       <= 1'b0;
      r_cur_buf    <= '0;
      r_frame_base <= BASE_ADDR;
    end else begin
      r_fs_sync    <= {r_fs_sync[0], frame_start};
      r_fs_d       <= r_fs_sync[1];
      r_cur_buf    <= w_cur_buf_nxt;
      r_frame_base <= BASE_ADDR + AW'(w_cur_buf_nxt) * BUF_STRIDE;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_araddr       <= BASE_ADDR;
      r_arvalid      <= 1'b0;
      r_rready       <= 1'b0;
      r_offset       <= '0;
      r_frame_done   <= 1'b0;
      r_restart_pend <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_araddr       <= w_araddr_nxt;
      r_arvalid      <= w_arvalid_nxt;
      r_rready       <= w_rready_nxt;
      r_offset       <= w_offset_nxt;
      r_frame_done   <= w_frame_done_nxt;
      r_restart_pend <= w_restart_pend_nxt;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt        = r_state;
    w_araddr_nxt       = r_araddr;
    w_arvalid_nxt      = r_arvalid;
    w_rready_nxt       = r_rready;
    w_offset_nxt       = r_offset;
    w_frame_done_nxt   = r_frame_done;
    w_restart_pend_nxt = r_restart_pend;
    w_wr_en_c          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fs_rise) begin
          w_offset_nxt     = '0;
          w_frame_done_nxt = 1'b0;
        end else if (!fifo_prog_full) begin
          w_araddr_nxt  = r_frame_base + r_offset;
          w_arvalid_nxt = 1'b1;
          w_state_nxt   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_fs_rise) w_restart_pend_nxt = 1'b1;
        if (r_arvalid && ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          // a restart seen while waiting still lets the granted burst run
          w_state_nxt   = (w_fs_rise || r_restart_pend) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        w_wr_en_c = w_rbeat;
        if (w_rlast) begin
          w_rready_nxt = 1'b0;
          if (w_fs_rise) begin
            // restart coincides with the last beat: nothing left to drain
            w_offset_nxt       = '0;
            w_frame_done_nxt   = 1'b0;
            w_restart_pend_nxt = 1'b0;
            w_state_nxt        = S_IDLE;
          end else if (r_offset + AW'(BB) == AW'(FRAME_BYTES)) begin
            w_frame_done_nxt = 1'b1;
            w_state_nxt      = S_DONE;
          end else begin
            w_offset_nxt = r_offset + AW'(BB);
            w_state_nxt  = S_IDLE;
          end
        end else if (w_fs_rise) begin
          w_restart_pend_nxt = 1'b1;
          w_state_nxt        = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // beats are accepted but discarded until the burst ends
        if (w_rlast) begin
          w_rready_nxt       = 1'b0;
          w_offset_nxt       = '0;
          w_frame_done_nxt   = 1'b0;
          w_restart_pend_nxt = 1'b0;
          w_state_nxt        = S_IDLE;
        end
      end
      S_DONE: begin
        if (w_fs_rise) begin
          w_offset_nxt     = '0;
          w_frame_done_nxt = 1'b0;
          w_state_nxt      = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ARADDR      = r_araddr;
  assign ARVALID     = r_arvalid;
  assign ARLEN       = 8'(BURST_LEN - 1);
  assign ARSIZE      = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign ARBURST     = 2'b01;
  assign ARCACHE     = 4'b1111;
  assign RREADY      = r_rready;
  assign fifo_wr_en  = w_wr_en_c;
  assign fifo_din    = RDATA;
  assign state       = 3'(r_state);
  assign addr_offset = r_offset;
  assign frame_done  = r_frame_done;

`ifdef RD_RESP_CHECK_EN
  logic        r_rd_err;
  logic [15:0] r_rd_err_cnt;

  // Sticky error flag and saturating count of non-OKAY read responses
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      r_rd_err     <= 1'b0;
      r_rd_err_cnt <= 16'h0000;
    end else if (w_rbeat && (RRESP != 2'b00)) begin
      r_rd_err <= 1'b1;
      if (r_rd_err_cnt != 16'hFFFF) r_rd_err_cnt <= r_rd_err_cnt + 16'd1;
    end
  end

  assign rd_err     = r_rd_err;
  assign rd_err_cnt = r_rd_err_cnt;
`else
  logic w_unused_rresp;
  assign w_unused_rresp = ^RRESP;
`endif

endmodule
